trace_uart_tx: RTL
==================

# trace_uart_tx

Hardware instruction-trace transmitter for the MIPS core. It captures each executed (PC, instruction) pair on the core's execute strobe and queues it in a small FIFO. Queued records are serialized off-chip over a UART 8N1 line, so a host sees on the board the same per-instruction trace the simulation bench prints. Sits beside `master`, fed from its `E`, `pc` and `mem_out` nets.

## Interface
- `CLKS_PER_BIT`, 434, external_clk cycles per UART bit (50 MHz / 115200); legal range ≥ 2
- `FIFO_DEPTH`, 4, record entries; power of two, ≥ 2
- `external_clk`  in  1  sole clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `ena`  in  1  global enable; low freezes the whole block
- `trace_valid`  in  1  one-cycle strobe, driven by core `E`
- `trace_pc`  in  32  PC of the executed instruction
- `trace_instr`  in  32  instruction word
- `tx`  out  1  UART line, idle high
- `busy`  out  1  high while FIFO is non-empty or a record is being sent
- `dropped_count`  out  8  records lost to FIFO overflow; saturates at 255

## Operation
- Reset values: `tx`=1, `busy`=0, `dropped_count`=0, FIFO empty, FSM in IDLE, bit timer 0.
- Capture: on an edge with `ena`=1 and `trace_valid`=1, push {pc, instr} as 64 bits.
  - Push is accepted if FIFO count < FIFO_DEPTH, or if a pop happens on the same edge.
  - Otherwise the record is discarded and `dropped_count` increments, saturating at 255.
- Record format: 9 bytes, sent in this order:
  - sync byte 0xA5;
  - pc[31:24], pc[23:16], pc[15:8], pc[7:0];
  - instr[31:24] … instr[7:0].
- Byte framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT enabled cycles.
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE → LOAD when the FIFO is non-empty. The pop happens on this edge and the record is latched into a 64-bit shift holding register.
  - LOAD → START on the next edge; byte index is set to 0.
  - START → DATA → STOP, with bit index 0..7 in DATA.
  - STOP with byte index < 8 → START for the next byte; there are no idle bits between the bytes of a record.
  - STOP with byte index 8 → IDLE; the next record may start on the following edge.
- `ena`=0: bit timer, FSM, FIFO and counter hold; `tx` holds its current level; `trace_valid` is ignored.
- `rst` mid-frame: all state returns to reset values on that edge; the partial frame is abandoned and `tx`=1 the next cycle.

## Timing
- `trace_valid` sampled at edge N, FIFO empty and IDLE:
  - record written at N;
  - LOAD at N+1;
  - `tx` falls after edge N+2.
- One record takes 90 × CLKS_PER_BIT cycles from the start-bit fall to the end of the final stop bit.
- `busy` is registered. It rises the edge after the first push and falls on the edge the FSM returns to IDLE with the FIFO empty.
- `tx` is driven directly from a flop, never combinationally.

## Structure
- Package `debug_pkg` holds:
  - `TRACE_SYNC_BYTE` = 8'hA5;
  - `TRACE_RECORD_BYTES` = 9;
  - `trace_rec_t`, a packed struct {pc, instr};
  - the FSM state enum.
- Sub-module `uart_tx_byte` handles one byte frame with a valid/ready handshake and CLKS_PER_BIT baud timing. The top level owns the FIFO, the record/byte sequencing and the drop counter.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Single record: pc=0x00400000, instr=0x20080005 → bytes A5 00 40 00 00 20 08 00 05 on `tx`, each bit 4 cycles, 360 cycles total; `busy` then falls and `dropped_count`=0.
- Overflow: 6 strobes on consecutive cycles → 5 records emitted in order and `dropped_count`=1.
- Saturation: 300 strobes while the FIFO is held full → `dropped_count`=255 and stays there.
- Reset mid-frame: `rst` pulsed during DATA of byte 3 → `tx`=1 and `busy`=0 next cycle; no further frames; a subsequent strobe yields a complete A5-led record.
- Enable stall: `ena` low for 10 cycles mid-bit → that bit lasts 14 cycles; a strobe during the stall is not captured; byte values are unaffected.
- Same-edge push/pop: FIFO full when IDLE→LOAD pops, with a strobe on that edge → strobe accepted, `dropped_count` unchanged.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and constants for the instruction-trace UART transmitter.
package debug_pkg;

    localparam logic [7:0] TRACE_SYNC_BYTE    = 8'hA5;
    localparam int         TRACE_RECORD_BYTES = 9;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } trace_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } trace_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// Serialises one byte as an 8N1 frame. The next byte is accepted in the final
// cycle of the stop bit, so back-to-back bytes leave no idle gap on the line.
module uart_tx_byte
    import debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ena_i,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int            TW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    trace_state_e  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (timer_q == TIMER_LAST);
    assign ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end);
    assign tx_o    = tx_q;

    // data_q shifts right as bits go out, so the next data bit is always data_q[1]
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;
        if (ena_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        state_d = ST_START;
                        timer_d = '0;
                        data_d  = data_i;
                        tx_d    = 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_d = ST_DATA;
                        timer_d = '0;
                        bit_d   = '0;
                        tx_d    = data_q[0];
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        timer_d = '0;
                        if (bit_q == 3'd7) begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end else begin
                            bit_d  = bit_q + 3'd1;
                            data_d = {1'b0, data_q[7:1]};
                            tx_d   = data_q[1];
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        timer_d = '0;
                        if (valid_i) begin
                            state_d = ST_START;
                            data_d  = data_i;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/trace_uart_tx.sv
// Instruction-trace transmitter: queues (pc, instr) records in a FIFO and streams
// each one as a sync byte plus 8 big-endian bytes over an 8N1 UART line.
module trace_uart_tx
    import debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        external_clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        trace_valid,
    input  logic [31:0] trace_pc,
    input  logic [31:0] trace_instr,
    output logic        tx,
    output logic        busy,
    output logic [7:0]  dropped_count
);

    localparam int            AW         = $clog2(FIFO_DEPTH);
    localparam int            CW         = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [3:0]    LAST_BYTE  = 4'(TRACE_RECORD_BYTES);

    trace_rec_t    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    drop_q, drop_d;

    trace_state_e  state_q, state_d;
    logic [3:0]    byte_idx_q, byte_idx_d;
    logic [63:0]   shift_q, shift_d;
    logic          busy_q, busy_d;

    logic          pop, push, drop;
    logic          byte_valid, byte_ready, byte_accept;
    logic [7:0]    byte_data;

    // A full FIFO still accepts a record when the sequencer pops on the same edge
    assign pop  = ena && (state_q == ST_IDLE) && (count_q != '0);
    assign push = ena && trace_valid && ((count_q != FULL_COUNT) || pop);
    assign drop = ena && trace_valid && !push;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge external_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= trace_rec_t'{pc: trace_pc, instr: trace_instr};
        end
    end

    always_ff @(posedge external_clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        byte_valid = 1'b0;
        byte_data  = shift_q[63:56];
        case (state_q)
            ST_LOAD: begin
                byte_valid = 1'b1;
                byte_data  = TRACE_SYNC_BYTE;
            end
            ST_DATA: byte_valid = (byte_idx_q != LAST_BYTE);
            default: byte_valid = 1'b0;
        endcase
    end

    assign byte_accept = ena && byte_valid && byte_ready;

    // ST_DATA covers the whole streaming phase; start/data/stop bit timing lives in uart_tx_byte
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d    = ST_LOAD;
                    shift_d    = fifo_mem[rd_ptr_q];
                    byte_idx_d = '0;
                end
            end
            ST_LOAD: begin
                if (byte_accept) begin
                    state_d    = ST_DATA;
                    byte_idx_d = 4'd1;
                end
            end
            ST_DATA: begin
                if (byte_accept) begin
                    shift_d    = {shift_q[55:0], 8'h00};
                    byte_idx_d = byte_idx_q + 4'd1;
                end else if (ena && byte_ready && (byte_idx_q == LAST_BYTE)) begin
                    state_d    = ST_IDLE;
                    byte_idx_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                byte_idx_d = '0;
            end
        endcase
        busy_d = (count_q != '0) || (state_d != ST_IDLE);
    end

    always_ff @(posedge external_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= '0;
            shift_q    <= '0;
            busy_q     <= 1'b0;
        end else if (ena) begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            busy_q     <= busy_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk_i  (external_clk),
        .rst_i  (rst),
        .ena_i  (ena),
        .valid_i(byte_valid),
        .data_i (byte_data),
        .ready_o(byte_ready),
        .tx_o   (tx)
    );

    assign busy          = busy_q;
    assign dropped_count = drop_q;

endmodule
